// File: rtl/rom_fetch_unit.sv
// Prefetching instruction fetch unit for a 1-cycle-latency synchronous program ROM.
// Optional per-entry fetch address output enabled by defining ROM_FETCH_ADDR_TAG_EN.
module rom_fetch_unit #(
  parameter int unsigned              ADDR_WIDTH = 8,
  parameter int unsigned              DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0]    RESET_ADDR = '0
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  output logic [ADDR_WIDTH-1:0] ROM_ADDR,
  input  logic [7:0]            ROM_DATA,
  input  logic                  HALT,
  input  logic                  JUMP_EN,
  input  logic [ADDR_WIDTH-1:0] JUMP_ADDR,
  output logic [7:0]            INSTR_DATA,
  output logic                  INSTR_VALID,
  input  logic                  INSTR_READY
`ifdef ROM_FETCH_ADDR_TAG_EN
  ,
  output logic [ADDR_WIDTH-1:0] INSTR_ADDR
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic                    pending_q;
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]        count_q;
  logic [7:0]              data_mem [DEPTH];

  logic                    pop, push, issue;
  logic [CNT_W-1:0]        count_after_pop;
  logic [CNT_W:0]          in_use;

  // Issue is gated by the state entered at this edge so HALT takes effect without delay.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (HALT)  state_d = STALL;
      STALL:   if (!HALT) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pop             = INSTR_VALID & INSTR_READY & ~JUMP_EN;
    push            = pending_q & ~JUMP_EN;
    count_after_pop = count_q - CNT_W'(pop);
    in_use          = (CNT_W+1)'(count_after_pop) + (CNT_W+1)'(pending_q);
    issue           = (state_d == RUN) & ~JUMP_EN & (in_use < (CNT_W+1)'(DEPTH));
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= RUN;
      pc_q      <= RESET_ADDR;
      pending_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) data_mem[i] <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= issue;
      if (JUMP_EN) begin
        pc_q     <= JUMP_ADDR;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (issue) pc_q <= pc_q + ADDR_WIDTH'(1);
        if (push) begin
          data_mem[wr_ptr_q] <= ROM_DATA;
          wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  assign ROM_ADDR    = pc_q;
  assign INSTR_VALID = (count_q != '0);
  assign INSTR_DATA  = data_mem[rd_ptr_q];

`ifdef ROM_FETCH_ADDR_TAG_EN
  logic [ADDR_WIDTH-1:0] inflight_addr_q;
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      inflight_addr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) addr_mem[i] <= '0;
    end else begin
      if (issue) inflight_addr_q <= pc_q;
      if (push)  addr_mem[wr_ptr_q] <= inflight_addr_q;
    end
  end

  assign INSTR_ADDR = addr_mem[rd_ptr_q];
`endif

endmodule
